// File: rtl/cam_capture_sequencer.sv
// cam_capture_sequencer: frame capture gate and geometry checker in the OV7670 pclk domain
// Define CAP_WATCHDOG_EN to build the WAIT_VS/CAPTURE watchdog.
module cam_capture_sequencer #(
    parameter int W       = 320,
    parameter int H       = 240,
    parameter int LCNT_W  = 9,
    parameter int FCNT_W  = 16,
    parameter int TIMEOUT = 2000000
) (
    input  logic              ov7670_pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic              arm_req,
    input  logic              single_mode,
    input  logic              we_in,
    output logic              we_out,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy,
    output logic              holding,
    output logic [FCNT_W-1:0] good_cnt,
    output logic [FCNT_W-1:0] err_cnt,
    output logic              timeout
);
    // Byte counter grows when LCNT_W cannot reach 2*W, so a full line never aliases.
    localparam int BCNT_W = (LCNT_W > $clog2(2*W+1)) ? LCNT_W : $clog2(2*W+1);
    localparam logic [BCNT_W-1:0] LINE_BYTES  = BCNT_W'(2*W);
    localparam logic [LCNT_W-1:0] FRAME_LINES = LCNT_W'(H);

    typedef enum logic [2:0] {IDLE, WAIT_VS, CAPTURE, CHECK, HOLD} state_t;
    state_t state;
    logic arm_s1, arm_s2, arm_s3, vsync_d, href_d, mode_q, bad_q;
    logic [LCNT_W-1:0] line_cnt;
    logic [BCNT_W-1:0] byte_cnt;
    logic arm_pulse, vs_fall, vs_rise, href_fall, frame_ok, wd_fire;

    assign arm_pulse = arm_s2 & ~arm_s3;
    assign vs_fall   = vsync_d & ~vsync;
    assign vs_rise   = ~vsync_d & vsync;
    assign href_fall = href_d & ~href;
    assign frame_ok  = (line_cnt == FRAME_LINES) && !bad_q;
    assign we_out    = we_in & (state == CAPTURE);
    assign busy      = state inside {WAIT_VS, CAPTURE, CHECK};
    assign holding   = state == HOLD;

`ifdef CAP_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT+1);
    logic [WD_W-1:0] wd_cnt;
    logic wd_run, timeout_q;
    assign wd_run  = (state == WAIT_VS || state == CAPTURE) && !vs_fall && !vs_rise;
    assign wd_fire = wd_run && wd_cnt == WD_W'(TIMEOUT-1);
    assign timeout = timeout_q;
    always_ff @(posedge ov7670_pclk or posedge reset) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt <= (wd_run && !wd_fire) ? wd_cnt + 1'b1 : '0;
            if (wd_fire) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ov7670_pclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            {arm_s1, arm_s2, arm_s3, vsync_d, href_d, mode_q, bad_q} <= 7'b0;
            line_cnt    <= '0;
            byte_cnt    <= '0;
            good_cnt    <= '0;
            err_cnt     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            {arm_s3, arm_s2, arm_s1} <= {arm_s2, arm_s1, arm_req};
            vsync_d     <= vsync;
            href_d      <= href;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            if (wd_fire) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
            end else begin
                case (state)
                    IDLE, HOLD: if (arm_pulse) begin
                        mode_q <= single_mode;
                        state  <= WAIT_VS;
                    end
                    WAIT_VS: if (vs_fall) begin
                        state       <= CAPTURE;
                        frame_start <= 1'b1;
                        line_cnt    <= '0;
                        byte_cnt    <= '0;
                        bad_q       <= 1'b0;
                    end
                    CAPTURE: begin
                        if (href_fall) begin
                            if (byte_cnt != LINE_BYTES) bad_q <= 1'b1;
                            if (~&line_cnt) line_cnt <= line_cnt + 1'b1;
                            byte_cnt <= '0;
                        end else if (href && ~&byte_cnt) byte_cnt <= byte_cnt + 1'b1;
                        if (vs_rise) state <= CHECK;
                    end
                    CHECK: begin
                        frame_done <= frame_ok;
                        frame_err  <= !frame_ok;
                        if (frame_ok) good_cnt <= good_cnt + 1'b1;
                        else if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
                        state <= (frame_ok && mode_q) ? HOLD : WAIT_VS;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_sequencer.sv
// tb_cam_capture_sequencer: random camera frames checked against a frame-level capture model
module tb_cam_capture_sequencer;
    localparam int W = 8, H = 6, LCNT_W = 9, FCNT_W = 4, TIMEOUT = 1000;
    localparam int LB = 2*W;
    localparam int CMAX = (1 << FCNT_W) - 1;

    logic ov7670_pclk = 0, reset = 1, vsync = 1, href = 0, arm_req = 0, single_mode = 0, we_in = 0;
    logic we_out, frame_start, frame_done, frame_err, busy, holding, timeout;
    logic [FCNT_W-1:0] good_cnt, err_cnt;

    int checks = 0, failures = 0;
    int n_start = 0, n_done = 0, n_err = 0, we_bad = 0;
    logic cap_exp = 0;

    typedef enum {M_IDLE, M_RUN, M_HOLD} mst_t;
    mst_t mst = M_IDLE;
    logic m_mode = 0;
    int m_good = 0, m_err = 0;

    cam_capture_sequencer #(.W(W), .H(H), .LCNT_W(LCNT_W), .FCNT_W(FCNT_W), .TIMEOUT(TIMEOUT)) dut (
        .ov7670_pclk(ov7670_pclk), .reset(reset), .vsync(vsync), .href(href),
        .arm_req(arm_req), .single_mode(single_mode), .we_in(we_in), .we_out(we_out),
        .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err),
        .busy(busy), .holding(holding), .good_cnt(good_cnt), .err_cnt(err_cnt), .timeout(timeout)
    );

    always #5 ov7670_pclk = ~ov7670_pclk;

    always @(negedge ov7670_pclk) begin
        if (frame_start) n_start++;
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if (we_out !== (we_in & cap_exp)) we_bad++;
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ov7670_pclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        cap_exp = 0;
        #1;
        chk("rst_we_out", we_out, 0);
        tick(2);
        reset = 0;
        mst = M_IDLE;
        m_good = 0;
        m_err = 0;
        chk("rst_busy", busy, 0);
        chk("rst_holding", holding, 0);
        chk("rst_good_cnt", good_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_pulses", {frame_start, frame_done, frame_err}, 0);
        tick(1);
    endtask

    task automatic arm(input logic sm);
        single_mode = sm;
        arm_req = 1;
        tick(5);
        arm_req = 0;
        single_mode = 1'($urandom_range(0, 1));
        tick(3);
        if (mst != M_RUN) begin
            mst = M_RUN;
            m_mode = sm;
        end
    endtask

    // nl lines; line bad_line gets bad_len bytes; reset asserted mid-line rst_line (-1 = none)
    task automatic frame(input int nl, input int bad_line, input int bad_len, input int rst_line);
        int bs, bd, be, bw, len;
        logic cap0, cap, good;
        bs = n_start; bd = n_done; be = n_err; bw = we_bad;
        cap0 = (mst == M_RUN);
        cap = cap0;
        good = (nl == H) && (bad_line < 0 || bad_line >= nl);
        vsync = 0;
        cap_exp = cap;
        tick(3);
        for (int l = 0; l < nl; l++) begin
            len = (l == bad_line) ? bad_len : LB;
            for (int b = 0; b < len; b++) begin
                href = 1;
                we_in = 1'($urandom_range(0, 1));
                if (l == rst_line && b == len / 2) begin
                    we_in = 1;
                    reset = 1;
                    cap_exp = 0;
                    #1;
                    chk("midrst_we_out", we_out, 0);
                    chk("midrst_busy", busy, 0);
                    chk("midrst_holding", holding, 0);
                    chk("midrst_good_cnt", good_cnt, 0);
                    chk("midrst_err_cnt", err_cnt, 0);
                    mst = M_IDLE;
                    m_good = 0;
                    m_err = 0;
                    cap = 0;
                end
                tick(1);
                reset = 0;
            end
            href = 0;
            we_in = 0;
            tick($urandom_range(2, 4));
        end
        vsync = 1;
        cap_exp = 0;
        tick(4);
        if (cap) begin
            if (good) begin
                m_good = (m_good + 1) % (CMAX + 1);
                if (m_mode) mst = M_HOLD;
            end else m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
        end
        chk("frame_start", n_start - bs, cap0);
        chk("frame_done", n_done - bd, cap && good);
        chk("frame_err", n_err - be, cap && !good);
        chk("good_cnt", good_cnt, m_good);
        chk("err_cnt", err_cnt, m_err);
        chk("holding", holding, mst == M_HOLD);
        chk("busy", busy, mst == M_RUN);
        chk("we_out", we_bad - bw, 0);
    endtask

    initial begin
        int t, nl, bl, bln;
        do_reset();
        frame(H, -1, 0, -1);
        arm(0);
        repeat (3) frame(H, -1, 0, -1);
        frame(H, -1, 0, 3);
        frame(H, -1, 0, -1);
        arm(1);
        frame(H, -1, 0, -1);
        frame(H, -1, 0, -1);
        arm(1);
        frame(H, -1, 0, -1);
        arm(1);
        frame(H, 2, LB - 1, -1);
        frame(H, -1, 0, -1);
        arm(1);
        frame(H - 1, -1, 0, -1);
        do_reset();
        arm(0);
        repeat (CMAX + 2) frame(H - 1, -1, 0, -1);
        do_reset();
        for (int i = 0; i < 45; i++) begin
            if ($urandom_range(0, 14) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) arm(1'($urandom_range(0, 1)));
            t = $urandom_range(0, 5);
            nl = H; bl = -1; bln = 0;
            if (t == 3) begin bl = $urandom_range(0, H - 1); bln = $urandom_range(1, LB - 1); end
            if (t == 4) begin bl = $urandom_range(0, H - 1); bln = $urandom_range(LB + 1, LB + 3); end
            if (t == 5) nl = $urandom_range(0, 1) ? H - 1 : H + 1;
            frame(nl, bl, bln, -1);
        end
`ifdef CAP_WATCHDOG_EN
        do_reset();
        arm(0);
        begin
            int be;
            be = n_err;
            tick(TIMEOUT - 20);
            chk("wd_early_timeout", timeout, 0);
            chk("wd_early_busy", busy, 1);
            tick(40);
            chk("wd_timeout", timeout, 1);
            chk("wd_frame_err", n_err - be, 1);
            chk("wd_err_cnt", err_cnt, 1);
            chk("wd_busy", busy, 0);
            tick(5);
            chk("wd_sticky", timeout, 1);
        end
`else
        chk("timeout_off", timeout, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
